// File: rtl/bist_tpg.sv
// BIST test-pattern generator: seeded 15-bit Fibonacci LFSR (x^15+x^14+1) stepped once per
// pattern, with start/done handshake, pattern counter, seed load and abort.
module bist_tpg #(
  parameter int          N_PATTERNS = 1000,
  parameter logic [14:0] SEED       = 15'h0001,
  parameter int          CNT_W      = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_ld,
  input  logic [14:0]      seed_in,
  output logic             t0,
  output logic             t1,
  output logic             t2,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [14:0]      lfsr_q
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

  state_t           state_q, state_d;
  logic [14:0]      seed_q, seed_d;
  logic [14:0]      lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [14:0]      seed_eff;
  logic [14:0]      run_seed;

  // A zero seed would lock the LFSR, so it is replaced by the default.
  assign seed_eff = (seed_in == 15'h0000) ? SEED : seed_in;
  assign run_seed = seed_ld ? seed_eff : seed_q;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (seed_ld) seed_d = seed_eff;
        if (start) begin
          state_d = RUN;
          lfsr_d  = run_seed;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (seed_ld) seed_d = seed_eff;
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d = RUN;
          lfsr_d  = run_seed;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status flags are decoded from the next state so they register alongside it.
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      seed_q  <= SEED;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign t0      = lfsr_q[0];
  assign t1      = lfsr_q[1];
  assign t2      = lfsr_q[2];
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pat_cnt = cnt_q;

endmodule

// File: tb/tb_bist_tpg.sv
// Directed self-checking bench for bist_tpg, including a TPG -> MISR loop-back signature.
module tb_bist_tpg;

  localparam int CNT_W = 10;
  localparam int NPAT  = 1000;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             seed_ld = 1'b0;
  logic [14:0]      seed_in = 15'h0000;
  logic             t0, t1, t2, valid, busy, done;
  logic [CNT_W-1:0] pat_cnt;
  logic [14:0]      lfsr_q;

  int n_cmp = 0;
  int n_err = 0;
  logic [14:0] first_sig;

  bist_tpg #(.N_PATTERNS(NPAT), .SEED(15'h0001), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .seed_ld(seed_ld),
    .seed_in(seed_in), .t0(t0), .t1(t1), .t2(t2), .valid(valid), .busy(busy),
    .done(done), .pat_cnt(pat_cnt), .lfsr_q(lfsr_q)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [14:0] misr_step(input logic [14:0] s, input logic [2:0] e);
    return {s[13:0], s[14] ^ s[13]} ^ {12'b0, e};
  endfunction

  // Starts a run and follows it to the end against an LFSR model, feeding both the DUT
  // stream and the model stream into MISRs. pulse_at raises start during that pattern;
  // flip_at inverts t0 of that pattern on its way into the DUT-side MISR.
  task automatic run_stream(input logic [14:0] seed, input int pulse_at, input int flip_at,
                            output int nvalid, output int nbad, output logic [14:0] sig_dut,
                            output logic [14:0] sig_ref, output logic [14:0] last_lfsr);
    logic [14:0] m;
    int guard;
    m = seed; nvalid = 0; nbad = 0; sig_dut = '0; sig_ref = '0; guard = 0; last_lfsr = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (valid === 1'b1 && guard < NPAT + 100) begin
      if (lfsr_q !== m || {t2, t1, t0} !== m[2:0] || pat_cnt !== CNT_W'(nvalid) ||
          busy !== 1'b1 || done !== 1'b0)
        nbad++;
      sig_dut   = misr_step(sig_dut, {t2, t1, t0} ^ ((nvalid == flip_at) ? 3'b001 : 3'b000));
      sig_ref   = misr_step(sig_ref, m[2:0]);
      last_lfsr = m;
      start     = (nvalid == pulse_at);
      m         = {m[13:0], m[14] ^ m[13]};
      nvalid++;
      tick();
      start = 1'b0;
      guard++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    n_cmp++;
    if ({valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {valid, busy, done});
    end
    n_cmp++;
    if (lfsr_q !== 15'h0001 || {t2, t1, t0} !== 3'b001) begin
      n_err++; $display("FAIL reset_lfsr: got %h t=%b want 0001 t=001", lfsr_q, {t2, t1, t0});
    end
    n_cmp++;
    if (pat_cnt !== '0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", pat_cnt);
    end
  endtask

  task automatic test_first_patterns();
    logic [2:0] exp_t [4];
    exp_t = '{3'b001, 3'b010, 3'b100, 3'b000};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({t2, t1, t0} !== exp_t[i] || valid !== 1'b1) begin
        n_err++; $display("FAIL first_pat%0d: got t=%b v=%b want t=%b v=1", i, {t2, t1, t0}, valid, exp_t[i]);
      end
      tick();
    end
    repeat (9) tick();
    n_cmp++;
    if (lfsr_q !== 15'h2000) begin
      n_err++; $display("FAIL pat13_lfsr: got %h want 2000", lfsr_q);
    end
    tick();
    n_cmp++;
    if (lfsr_q !== 15'h4001) begin
      n_err++; $display("FAIL pat14_lfsr: got %h want 4001", lfsr_q);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_full_run();
    int nv, nb, bad;
    logic [14:0] sd, sr, ll;
    run_stream(15'h0001, -1, -1, nv, nb, sd, sr, ll);
    first_sig = sd;
    n_cmp++;
    if (nv !== NPAT) begin
      n_err++; $display("FAIL run_len: got %0d valid cycles want %0d", nv, NPAT);
    end
    n_cmp++;
    if (nb !== 0) begin
      n_err++; $display("FAIL run_stream: got %0d bad cycles want 0", nb);
    end
    n_cmp++;
    if (done !== 1'b1 || pat_cnt !== CNT_W'(NPAT - 1) || lfsr_q !== ll) begin
      n_err++; $display("FAIL run_end: got done=%b cnt=%0d lfsr=%h want 1 %0d %h", done, pat_cnt, lfsr_q, NPAT - 1, ll);
    end
    n_cmp++;
    if (sd !== sr) begin
      n_err++; $display("FAIL signature: got %h want %h", sd, sr);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b1 || valid !== 1'b0 || lfsr_q !== ll) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL done_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_repeat();
    int nv, nb;
    logic [14:0] sd, sr, ll;
    run_stream(15'h0001, -1, -1, nv, nb, sd, sr, ll);
    n_cmp++;
    if (nv !== NPAT || nb !== 0) begin
      n_err++; $display("FAIL repeat_stream: got len=%0d bad=%0d want %0d 0", nv, nb, NPAT);
    end
    n_cmp++;
    if (sd !== first_sig) begin
      n_err++; $display("FAIL repeat_sig: got %h want %h", sd, first_sig);
    end
  endtask

  task automatic test_start_during_run();
    int nv, nb;
    logic [14:0] sd, sr, ll;
    run_stream(15'h0001, 100, -1, nv, nb, sd, sr, ll);
    n_cmp++;
    if (nv !== NPAT || nb !== 0) begin
      n_err++; $display("FAIL start_in_run: got len=%0d bad=%0d want %0d 0", nv, nb, NPAT);
    end
  endtask

  task automatic test_flip();
    int nv, nb;
    logic [14:0] sd, sr, ll;
    run_stream(15'h0001, -1, 5, nv, nb, sd, sr, ll);
    n_cmp++;
    if (nv !== NPAT || sd === sr) begin
      n_err++; $display("FAIL flip_sig: got len=%0d sig=%h want %0d and sig differing from %h", nv, sd, NPAT, sr);
    end
  endtask

  task automatic test_seed_load();
    seed_ld = 1'b1; seed_in = 15'h0000;
    tick();
    seed_ld = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({t2, t1, t0} !== 3'b001 || lfsr_q !== 15'h0001 || valid !== 1'b1) begin
      n_err++; $display("FAIL seed_zero: got t=%b lfsr=%h v=%b want 001 0001 1", {t2, t1, t0}, lfsr_q, valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    seed_ld = 1'b1; seed_in = 15'h7FFF; start = 1'b1;
    tick();
    seed_ld = 1'b0; start = 1'b0;
    n_cmp++;
    if ({t2, t1, t0} !== 3'b111 || valid !== 1'b1) begin
      n_err++; $display("FAIL seed_7fff_p0: got t=%b v=%b want 111 1", {t2, t1, t0}, valid);
    end
    tick();
    n_cmp++;
    if (lfsr_q !== 15'h7FFE) begin
      n_err++; $display("FAIL seed_7fff_p1: got %h want 7ffe", lfsr_q);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [14:0] hold;
    int bad;
    seed_ld = 1'b1; seed_in = 15'h0000;
    tick();
    seed_ld = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (500) tick();
    n_cmp++;
    if (pat_cnt !== CNT_W'(500) || valid !== 1'b1) begin
      n_err++; $display("FAIL abort_pre: got cnt=%0d v=%b want 500 1", pat_cnt, valid);
    end
    hold = lfsr_q;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({valid, busy, done} !== 3'b000 || pat_cnt !== '0 || lfsr_q !== hold) begin
      n_err++; $display("FAIL abort_post: got vbd=%b cnt=%0d lfsr=%h want 000 0 %h", {valid, busy, done}, pat_cnt, lfsr_q, hold);
    end
    bad = 0;
    for (int i = 0; i < NPAT; i++) begin
      tick();
      if (done !== 1'b0 || valid !== 1'b0 || lfsr_q !== hold) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL abort_idle: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_abort_start_done();
    int nv, nb;
    logic [14:0] sd, sr, ll;
    run_stream(15'h0001, -1, -1, nv, nb, sd, sr, ll);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL as_pre_done: got %b want 1", done);
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    tick();
    n_cmp++;
    if ({valid, busy, done} !== 3'b000 || pat_cnt !== '0) begin
      n_err++; $display("FAIL abort_start_done: got vbd=%b cnt=%0d want 000 0", {valid, busy, done}, pat_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    n_cmp++;
    if (pat_cnt !== CNT_W'(300) || valid !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: got cnt=%0d v=%b want 300 1", pat_cnt, valid);
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    n_cmp++;
    if ({valid, busy, done} !== 3'b000 || lfsr_q !== 15'h0001 || pat_cnt !== '0) begin
      n_err++; $display("FAIL rst_mid: got vbd=%b lfsr=%h cnt=%0d want 000 0001 0", {valid, busy, done}, lfsr_q, pat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_patterns();
    test_full_run();
    test_repeat();
    test_start_during_run();
    test_flip();
    test_seed_load();
    test_abort();
    test_abort_start_done();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
